// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl
//  Purpose  : Machine-mode trap / MRET controller. Accepts committed results,
//             records exceptions into mepc/mcause/mtval/mstatus, handles MRET,
//             then sequences a one-cycle pipeline flush followed by a PC
//             redirect (to mtvec for a trap, to mepc for MRET). Also provides
//             a simple CSR read/write port for the machine trap CSRs.
//  Ports    : clk, rst                    - clock, synchronous active-high reset
//             commit_valid/ready/pc/ex_valid/ex/tval/ret_valid - commit input
//             flush                       - kill younger in-flight instructions
//             redirect_valid/ready/target - fetch redirect handshake
//             csr_we/addr/wdata/rdata     - CSR port (rdata combinational)
//  Options  : define TRAP_CTRL_MTVAL_EN to implement mtval storage; when
//             undefined mtval reads 0, ignores writes and commit_tval is unused.
//  Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
  parameter int XLEN = 32,
  parameter int EX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            commit_ex_valid,
  input  logic [EX_W-1:0] commit_ex,
  input  logic [XLEN-1:0] commit_tval,
  input  logic            commit_ret_valid,
  output logic            flush,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_target,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  // mtvec (direct mode) and mepc are word aligned: low two bits always zero
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mtval;
  logic [EX_W-1:0] mcause;
  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] target;

  logic accept;
  logic take_trap;
  logic take_mret;
  logic we_mstatus;
  logic we_mtvec;
  logic we_mepc;
  logic we_mcause;

  assign accept    = commit_valid && (state == S_IDLE);
  // A simultaneous ex_valid/ret_valid is a trap; the MRET is dropped.
  assign take_trap = accept && commit_ex_valid;
  assign take_mret = accept && commit_ret_valid && !commit_ex_valid;

  assign we_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);
  assign we_mtvec   = csr_we && (csr_addr == ADDR_MTVEC);
  assign we_mepc    = csr_we && (csr_addr == ADDR_MEPC);
  assign we_mcause  = csr_we && (csr_addr == ADDR_MCAUSE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (take_trap || take_mret) state_next = S_FLUSH;
      S_FLUSH:    state_next = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    commit_ready   = (state == S_IDLE);
    flush          = (state == S_FLUSH);
    redirect_valid = (state == S_REDIRECT);
  end

  assign redirect_target = target;

  // ---------------- CSRs and redirect target ----------------
  // Trap/MRET updates take priority over a same-cycle CSR write on the
  // fields they touch; the write still lands everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec  <= '0;
      mepc   <= '0;
      mcause <= '0;
      mie    <= 1'b0;
      mpie   <= 1'b0;
      target <= '0;
    end else begin
      if (we_mtvec) mtvec <= csr_wdata & ALIGN_MASK;

      if (take_trap) begin
        mepc   <= commit_pc & ALIGN_MASK;
        mcause <= commit_ex;
      end else begin
        if (we_mepc)   mepc   <= csr_wdata & ALIGN_MASK;
        if (we_mcause) mcause <= csr_wdata[EX_W-1:0];
      end

      if (take_trap) begin
        mpie <= mie;
        mie  <= 1'b0;
      end else if (take_mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (we_mstatus) begin
        mie  <= csr_wdata[3];
        mpie <= csr_wdata[7];
      end

      // Target is taken from the pre-edge mtvec/mepc, so a same-cycle CSR
      // write to either cannot leak into this redirect.
      if (take_trap)      target <= mtvec;
      else if (take_mret) target <= mepc;
    end
  end

`ifdef TRAP_CTRL_MTVAL_EN
  logic we_mtval;
  assign we_mtval = csr_we && (csr_addr == ADDR_MTVAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      mtval <= '0;
    end else if (take_trap) begin
      mtval <= commit_tval;
    end else if (we_mtval) begin
      mtval <= csr_wdata;
    end
  end
`else
  logic unused_tval;
  assign mtval       = '0;
  assign unused_tval = ^commit_tval;
`endif

  // ---------------- CSR read mux ----------------
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = mpie;
        csr_rdata[3]     = mie;
      end
      ADDR_MTVEC:  csr_rdata = mtvec;
      ADDR_MEPC:   csr_rdata = mepc;
      ADDR_MCAUSE: csr_rdata[EX_W-1:0] = mcause;
      ADDR_MTVAL:  csr_rdata = mtval;
      default:     csr_rdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_trap_ctrl
//  Purpose  : Self-checking bench for trap_ctrl: CSR vector table, directed
//             trap/MRET/backpressure/reset sequences and randomized traffic
//             compared against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_ex_valid;
  logic [3:0]  commit_ex;
  logic [31:0] commit_tval;
  logic        commit_ret_valid;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_target;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .EX_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_pc        (commit_pc),
    .commit_ex_valid  (commit_ex_valid),
    .commit_ex        (commit_ex),
    .commit_tval      (commit_tval),
    .commit_ret_valid (commit_ret_valid),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_ready   (redirect_ready),
    .redirect_target  (redirect_target),
    .csr_we           (csr_we),
    .csr_addr         (csr_addr),
    .csr_wdata        (csr_wdata),
    .csr_rdata        (csr_rdata)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // m_busy counts the cycles of the post-event sequence:
  // 0 = accepting commits, 1 = flush cycle, 2 = waiting for redirect handshake
  int          m_busy;
  logic [31:0] m_mtvec, m_mepc, m_mtval, m_target;
  int          m_mcause;
  bit          m_mie, m_mpie;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return 32'(m_mcause);
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update();
    bit          acc, trap, mret;
    logic [31:0] old_mtvec, old_mepc;
    if (rst) begin
      m_busy = 0; m_mtvec = 0; m_mepc = 0; m_mtval = 0; m_target = 0;
      m_mcause = 0; m_mie = 0; m_mpie = 0;
      return;
    end
    acc  = commit_valid && (m_busy == 0);
    trap = acc && commit_ex_valid;
    mret = acc && commit_ret_valid && !commit_ex_valid;
    old_mtvec = m_mtvec;
    old_mepc  = m_mepc;
    if (csr_we) begin
      case (csr_addr)
        12'h300: if (!trap && !mret) begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
        12'h305: m_mtvec = csr_wdata & 32'hFFFF_FFFC;
        12'h341: if (!trap) m_mepc = csr_wdata & 32'hFFFF_FFFC;
        12'h342: if (!trap) m_mcause = int'(csr_wdata % 16);
`ifdef TRAP_CTRL_MTVAL_EN
        12'h343: if (!trap) m_mtval = csr_wdata;
`endif
        default: ;
      endcase
    end
    if (trap) begin
      m_target = old_mtvec;
      m_mepc   = commit_pc & 32'hFFFF_FFFC;
      m_mcause = int'(commit_ex);
`ifdef TRAP_CTRL_MTVAL_EN
      m_mtval  = commit_tval;
`endif
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (mret) begin
      m_target = old_mepc;
      m_mie    = m_mpie;
      m_mpie   = 1;
    end
    if (trap || mret)                    m_busy = 1;
    else if (m_busy == 1)                m_busy = 2;
    else if (m_busy == 2 && redirect_ready) m_busy = 0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are set at posedge+1; settle compares every output with the model.
  task automatic settle();
    #1;
    chk("flush",           32'(flush),          32'(m_busy == 1));
    chk("redirect_valid",  32'(redirect_valid), 32'(m_busy == 2));
    chk("commit_ready",    32'(commit_ready),   32'(m_busy == 0));
    chk("redirect_target", redirect_target,     m_target);
    chk("csr_rdata",       csr_rdata,           m_read(csr_addr));
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic idle_inputs();
    rst = 0; commit_valid = 0; commit_ex_valid = 0; commit_ret_valid = 0;
    commit_pc = 0; commit_ex = 0; commit_tval = 0; redirect_ready = 0;
    csr_we = 0; csr_addr = 12'h000; csr_wdata = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    idle_inputs();
    csr_we = 1; csr_addr = a; csr_wdata = d;
    settle();
    advance();
    csr_we = 0;
  endtask

  task automatic commit_trap(input logic [31:0] pc, input logic [3:0] ex, input logic [31:0] tval);
    idle_inputs();
    commit_valid = 1; commit_ex_valid = 1; commit_pc = pc; commit_ex = ex; commit_tval = tval;
    settle();
    chk("trap_accept_ready", 32'(commit_ready), 32'd1);
    advance();
    idle_inputs();
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } csr_vec_t;

  csr_vec_t tbl[8];
  logic [31:0] exp_tval;
  logic [11:0] addr_pool[6];

  initial begin
    tbl[0] = '{12'h305, 32'h8000_0103, 32'h8000_0100};
    tbl[1] = '{12'h341, 32'h1234_5677, 32'h1234_5674};
    tbl[2] = '{12'h342, 32'hFFFF_FFFF, 32'h0000_000F};
    tbl[3] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
    tbl[4] = '{12'h300, 32'h0000_0000, 32'h0000_1800};
`ifdef TRAP_CTRL_MTVAL_EN
    tbl[5] = '{12'h343, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    exp_tval = 32'hABCD_0000;
`else
    tbl[5] = '{12'h343, 32'hDEAD_BEEF, 32'h0000_0000};
    exp_tval = 32'h0;
`endif
    tbl[6] = '{12'h340, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[7] = '{12'h342, 32'h8000_000B, 32'h0000_000B};
    addr_pool = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h340};

    // ---- reset ----
    idle_inputs();
    rst = 1;
    advance();
    advance();
    rst = 0;
    settle();
    peek("rst_mstatus", 12'h300, 32'h0000_1800);
    peek("rst_mtvec",   12'h305, 32'h0);
    peek("rst_mepc",    12'h341, 32'h0);
    peek("rst_mcause",  12'h342, 32'h0);
    peek("rst_mtval",   12'h343, 32'h0);
    advance();

    // ---- CSR write/read vector table ----
    for (int i = 0; i < 8; i++) begin
      csr_write(tbl[i].addr, tbl[i].wdata);
      idle_inputs();
      csr_addr = tbl[i].addr;
      settle();
      chk($sformatf("table[%0d]", i), csr_rdata, tbl[i].exp);
      advance();
    end

    // ---- trap ----
    csr_write(12'h305, 32'h8000_0103);
    csr_write(12'h300, 32'h0000_0008);
    commit_trap(32'h8000_0010, 4'd11, 32'h0);
    settle();
    chk("trap_flush", 32'(flush), 32'd1);
    chk("trap_flush_rv", 32'(redirect_valid), 32'd0);
    peek("trap_mtvec",   12'h305, 32'h8000_0100);
    peek("trap_mepc",    12'h341, 32'h8000_0010);
    peek("trap_mcause",  12'h342, 32'd11);
    peek("trap_mstatus", 12'h300, 32'h0000_1880);
    advance();
    settle();
    chk("trap_flush_one_cycle", 32'(flush), 32'd0);
    chk("trap_rv", 32'(redirect_valid), 32'd1);
    chk("trap_target", redirect_target, 32'h8000_0100);
    redirect_ready = 1;
    advance();
    idle_inputs();
    settle();
    chk("trap_back_idle", 32'(commit_ready), 32'd1);
    advance();

    // ---- MRET ----
    csr_write(12'h341, 32'h8000_0014);
    idle_inputs();
    commit_valid = 1; commit_ret_valid = 1;
    settle();
    advance();
    idle_inputs();
    settle();
    chk("mret_flush", 32'(flush), 32'd1);
    peek("mret_mstatus", 12'h300, 32'h0000_1888);
    advance();
    settle();
    chk("mret_rv", 32'(redirect_valid), 32'd1);
    chk("mret_target", redirect_target, 32'h8000_0014);
    redirect_ready = 1;
    advance();

    // ---- redirect backpressure; offered commit waits ----
    commit_trap(32'h8000_0020, 4'd2, 32'h0);
    commit_valid = 1; commit_ex_valid = 1; commit_ex = 4'd5; commit_pc = 32'h8000_0040;
    settle();
    chk("bp_flush", 32'(flush), 32'd1);
    advance();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_rv", 32'(redirect_valid), 32'd1);
      chk("bp_target", redirect_target, 32'h8000_0100);
      chk("bp_ready", 32'(commit_ready), 32'd0);
      peek("bp_mcause", 12'h342, 32'd2);
      advance();
    end
    redirect_ready = 1;
    settle();
    chk("bp_handshake_rv", 32'(redirect_valid), 32'd1);
    advance();
    redirect_ready = 0;
    settle();
    chk("bp_idle_ready", 32'(commit_ready), 32'd1);
    peek("bp_not_yet_mcause", 12'h342, 32'd2);
    peek("bp_not_yet_mepc",   12'h341, 32'h8000_0020);
    advance();
    idle_inputs();
    settle();
    chk("bp_second_flush", 32'(flush), 32'd1);
    peek("bp_second_mcause", 12'h342, 32'd5);
    peek("bp_second_mepc",   12'h341, 32'h8000_0040);
    advance();
    redirect_ready = 1;
    settle();
    advance();

    // ---- ex+ret together with same-cycle mcause write ----
    idle_inputs();
    commit_valid = 1; commit_ex_valid = 1; commit_ret_valid = 1; commit_ex = 4'd3;
    commit_pc = 32'h8000_0050; commit_tval = 32'hABCD_0000;
    csr_we = 1; csr_addr = 12'h342; csr_wdata = 32'd7;
    settle();
    advance();
    idle_inputs();
    settle();
    chk("both_flush", 32'(flush), 32'd1);
    peek("both_mcause", 12'h342, 32'd3);
    peek("both_mtval",  12'h343, exp_tval);
    advance();
    settle();
    chk("both_target", redirect_target, 32'h8000_0100);
    redirect_ready = 1;
    advance();

    // ---- same-cycle mtvec write does not affect latched target ----
    idle_inputs();
    commit_valid = 1; commit_ex_valid = 1; commit_ex = 4'd1; commit_pc = 32'h8000_0060;
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h0000_0040;
    settle();
    advance();
    idle_inputs();
    settle();
    peek("mtvec_wr_value", 12'h305, 32'h0000_0040);
    advance();
    settle();
    chk("mtvec_wr_target", redirect_target, 32'h8000_0100);

    // ---- reset during REDIRECT ----
    rst = 1;
    advance();
    idle_inputs();
    settle();
    chk("rst_redir_rv", 32'(redirect_valid), 32'd0);
    chk("rst_redir_ready", 32'(commit_ready), 32'd1);
    chk("rst_redir_target", redirect_target, 32'h0);
    peek("rst_redir_mepc", 12'h341, 32'h0);
    peek("rst_redir_mstatus", 12'h300, 32'h0000_1800);
    advance();

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 800; i++) begin
      rst              = ($urandom_range(0, 99) == 0);
      commit_valid     = $urandom_range(0, 1) == 1;
      commit_ex_valid  = ($urandom_range(0, 3) == 0);
      commit_ret_valid = ($urandom_range(0, 3) == 0);
      commit_ex        = 4'($urandom);
      commit_pc        = $urandom;
      commit_tval      = $urandom;
      redirect_ready   = $urandom_range(0, 1) == 1;
      csr_we           = ($urandom_range(0, 2) == 0);
      csr_addr         = addr_pool[$urandom_range(0, 5)];
      csr_wdata        = $urandom;
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
